// File: rtl/ping_transmitter.sv
// Ultrasonic ping frame generator: tone burst, ring-down blanking, hold-off, then done.
// Optional build macro PING_AUTO_REPEAT_EN makes every IDLE cycle self-start a new frame.
module ping_transmitter #(
  parameter int unsigned HALF_PERIOD   = 1250,
  parameter int unsigned BLANK_CYCLES  = 50000,
  parameter int unsigned PERIOD_CYCLES = 600000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [3:0] burst_cycles_in,
  output logic       tx_out,
  output logic       trigger_out,
  output logic       blanking_out,
  output logic       busy_out,
  output logic       done_out
);

  typedef enum logic [1:0] {IDLE, BURST, BLANK, HOLDOFF} state_t;

  localparam logic [31:0] TONE_LEN  = 32'(2 * HALF_PERIOD);
  localparam logic [31:0] BLANK_LEN = 32'(BLANK_CYCLES);
  localparam logic [31:0] LAST_F    = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] HP_LAST   = 32'(HALF_PERIOD - 1);

  // The longest burst plus ring-down must fit inside one frame.
  if (PERIOD_CYCLES <= 2 * 15 * HALF_PERIOD + BLANK_CYCLES) begin : g_bad_cfg
    $error("ping_transmitter: PERIOD_CYCLES too short for max burst plus blanking");
  end

  state_t      state_q, state_d;
  logic [31:0] f_q, f_d;
  logic [3:0]  n_q, n_d;
  logic [31:0] hp_q, hp_d;
  logic        tone_q, tone_d;
  logic        tx_q, tx_d;
  logic        trig_q, trig_d;
  logic        blank_q, blank_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        go;
  logic [31:0] burst_len;
  logic [31:0] blank_end;

`ifdef PING_AUTO_REPEAT_EN
  assign go = 1'b1;
`else
  assign go = start_in;
`endif

  assign burst_len = {28'd0, n_q} * TONE_LEN;
  assign blank_end = burst_len + BLANK_LEN;

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    n_d     = n_q;
    hp_d    = hp_q;
    tone_d  = tone_q;
    trig_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = BURST;
          f_d     = 32'd0;
          n_d     = (burst_cycles_in == 4'd0) ? 4'd1 : burst_cycles_in;
          hp_d    = 32'd0;
          tone_d  = 1'b1;
          trig_d  = 1'b1;
        end
      end
      default: begin
        if (f_q == LAST_F) begin
          state_d = IDLE;
          f_d     = 32'd0;
          done_d  = 1'b1;
        end else begin
          f_d = f_q + 32'd1;
          // Half-period phase counter replaces a divide of f by HALF_PERIOD.
          if (hp_q == HP_LAST) begin
            hp_d   = 32'd0;
            tone_d = ~tone_q;
          end else begin
            hp_d = hp_q + 32'd1;
          end
          if (f_d < burst_len)      state_d = BURST;
          else if (f_d < blank_end) state_d = BLANK;
          else                      state_d = HOLDOFF;
        end
      end
    endcase
    tx_d    = (state_d == BURST) && tone_d;
    blank_d = (state_d == BURST) || (state_d == BLANK);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      f_q     <= 32'd0;
      n_q     <= 4'd1;
      hp_q    <= 32'd0;
      tone_q  <= 1'b0;
      tx_q    <= 1'b0;
      trig_q  <= 1'b0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      n_q     <= n_d;
      hp_q    <= hp_d;
      tone_q  <= tone_d;
      tx_q    <= tx_d;
      trig_q  <= trig_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_out       = tx_q;
  assign trigger_out  = trig_q;
  assign blanking_out = blank_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_ping_transmitter.sv
// Scoreboarded bench for ping_transmitter: a frame-time reference model queues the expected
// output vector each clock; a negedge monitor pops and compares it against the DUT.
module tb_ping_transmitter;

  localparam int HP  = 4;
  localparam int BL  = 10;
  localparam int PER = 200;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       start_in;
  logic [3:0] burst_cycles_in;
  logic       tx_out, trigger_out, blanking_out, busy_out, done_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ping_transmitter #(
    .HALF_PERIOD  (HP),
    .BLANK_CYCLES (BL),
    .PERIOD_CYCLES(PER)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .burst_cycles_in(burst_cycles_in),
    .tx_out         (tx_out),
    .trigger_out    (trigger_out),
    .blanking_out   (blanking_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a frame is a span of PER cycles indexed by m_f, followed by one done cycle.
  bit          m_active = 1'b0;
  int          m_f      = 0;
  int          m_n      = 1;
  logic [4:0]  model_e;
  logic [4:0]  exp_q[$];

  // Expected {tx, trigger, blanking, busy, done} for frame index f with N tone periods.
  function automatic logic [4:0] frame_out(input int f, input int n);
    logic tx, bl;
    tx = (f < 2 * n * HP) && (((f / HP) % 2) == 0);
    bl = (f < 2 * n * HP + BL);
    return {tx, (f == 0), bl, 1'b1, 1'b0};
  endfunction

  function automatic bit model_go();
`ifdef PING_AUTO_REPEAT_EN
    return 1'b1;
`else
    return start_in;
`endif
  endfunction

  always @(posedge clk_in) begin
    cyc++;
    model_e = 5'b0;
    if (rst_in) begin
      m_active = 1'b0;
      m_f      = 0;
      m_n      = 1;
    end else if (m_active) begin
      if (m_f == PER - 1) begin
        m_active = 1'b0;
        model_e  = 5'b00001;
      end else begin
        m_f++;
        model_e = frame_out(m_f, m_n);
      end
    end else if (model_go()) begin
      m_active = 1'b1;
      m_f      = 0;
      m_n      = (burst_cycles_in == 4'd0) ? 1 : int'(burst_cycles_in);
      model_e  = frame_out(0, m_n);
    end
    exp_q.push_back(model_e);
  end

  // Monitor: compares every presented output vector against the oldest queued expectation.
  always @(negedge clk_in) begin
    logic [4:0] got, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {tx_out, trigger_out, blanking_out, busy_out, done_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs cyc=%0d {tx,trig,blank,busy,done} got %b expected %b", cyc, got, want);
      end
    end
  end

  task automatic wait_f(input int target);
    int k = 0;
    while (!(m_active && m_f == target) && k < 1000) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= 1000) begin
      checks++;
      errors++;
      $display("FAIL wait_f timeout target=%0d got f=%0d", target, m_f);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_active && k < 1000) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= 1000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout got active=%0d expected 0", m_active);
    end
  endtask

  task automatic pulse_start(input logic [3:0] b);
    start_in        = 1'b1;
    burst_cycles_in = b;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  initial begin
    rst_in          = 1'b1;
    start_in        = 1'b0;
    burst_cycles_in = 4'd0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    // Single ping, N=2, then a short idle gap.
    pulse_start(4'd2);
    wait_idle();
    repeat (3) @(negedge clk_in);

    // N=0 behaves as one tone period.
    pulse_start(4'd0);
    wait_idle();
    @(negedge clk_in);

    // Mid-frame request ignored; a held request starts the next frame right after done.
    pulse_start(4'd3);
    wait_f(50);
    pulse_start(4'd5);
    wait_f(150);
    start_in = 1'b1;
    wait_idle();
    wait_f(0);
    start_in = 1'b0;
    wait_idle();
    @(negedge clk_in);

    // Reset abort at f=6, then start on the first cycle after release.
    pulse_start(4'd2);
    wait_f(6);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    pulse_start(4'd1);
    wait_idle();
    @(negedge clk_in);

    // Burst length latched at frame start.
    pulse_start(4'd3);
    wait_f(5);
    burst_cycles_in = 4'd1;
    wait_idle();

    // Back-to-back start on the done cycle.
    pulse_start(4'd15);
    wait_f(PER - 1);
    @(negedge clk_in);
    pulse_start(4'd7);
    wait_idle();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      start_in        = ($urandom_range(0, 7) == 0);
      burst_cycles_in = 4'($urandom_range(0, 15));
      rst_in          = ($urandom_range(0, 399) == 0);
      @(negedge clk_in);
    end
    rst_in   = 1'b0;
    start_in = 1'b0;
    repeat (2) @(negedge clk_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d expected finish earlier", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ping_transmitter.md
PING_TRANSMITTER -- requirements
Module: ping_transmitter

Interface
REQ-001 SHALL provide parameter HALF_PERIOD, default 1250, meaning clk_in cycles per half of the transducer tone (40 kHz at 100 MHz).
REQ-002 SHALL provide parameter BLANK_CYCLES, default 50000, meaning ring-down mask length after the burst, in cycles.
REQ-003 SHALL provide parameter PERIOD_CYCLES, default 600000, meaning frame length from trigger to frame end, in cycles; it SHALL exceed the 5 ms echo window.
REQ-004 SHALL provide port clk_in, input, 1 bit: the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL provide port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL provide port start_in, input, 1 bit: ping request, sampled only in IDLE.
REQ-007 SHALL provide port burst_cycles_in, input, 4 bits: tone periods per burst, latched on frame start.
REQ-008 SHALL provide port tx_out, output, 1 bit: transducer drive square wave.
REQ-009 SHALL provide port trigger_out, output, 1 bit: one-cycle pulse marking frame start, consumed by the ToF receiver.
REQ-010 SHALL provide port blanking_out, output, 1 bit: high while echoes are to be ignored (burst plus ring-down).
REQ-011 SHALL provide port busy_out, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL provide port done_out, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-013 SHALL implement states IDLE, BURST, BLANK, HOLDOFF, with all outputs registered.
REQ-014 SHALL, in IDLE with start_in=1, enter BURST next cycle; that cycle is frame count f=0, with trigger_out=1, tx_out=1, busy_out=1, blanking_out=1.
REQ-015 SHALL latch N=burst_cycles_in at acceptance; N=0 SHALL be treated as N=1.
REQ-016 SHALL keep a frame counter f, 0 on the first BURST cycle, incrementing by 1 per cycle, at least 32 bits wide.
REQ-017 SHALL, in BURST, drive tx_out=1 when floor(f/HALF_PERIOD) is even and 0 otherwise; BURST lasts exactly 2*N*HALF_PERIOD cycles (BURST_LEN).
REQ-018 SHALL, at f=BURST_LEN, enter BLANK with tx_out=0; BLANK lasts BLANK_CYCLES cycles, with blanking_out=1 throughout.
REQ-019 SHALL, at f=BURST_LEN+BLANK_CYCLES, enter HOLDOFF with blanking_out=0 and tx_out=0.
REQ-020 SHALL, on the cycle after f=PERIOD_CYCLES-1, return to IDLE with busy_out=0 and done_out=1 for exactly that cycle.
REQ-021 SHALL ignore start_in outside IDLE; there is no queueing, and a request held high across frame end starts a new frame on the first IDLE cycle.
REQ-022 SHALL accept a start_in on the same cycle done_out is high (back-to-back), giving a minimum IDLE dwell of 1 cycle.
REQ-023 SHALL ignore burst_cycles_in changes mid-frame.
REQ-024 SHALL be constrained so that PERIOD_CYCLES > 2*15*HALF_PERIOD + BLANK_CYCLES; a violation SHALL be flagged at elaboration (assertion) and is not supported at runtime.

Reset
REQ-025 SHALL, with rst_in=1 on a rising edge, force IDLE, f=0, N=1, and tx_out, trigger_out, blanking_out, busy_out, done_out all 0 next cycle.
REQ-026 SHALL treat reset mid-frame (any state) as an abort: no done_out pulse, and tx_out low the following cycle.
REQ-027 SHALL honor start_in on the first cycle after rst_in deasserts.

Configuration
REQ-028 SHALL, with macro PING_AUTO_REPEAT_EN defined, self-start a frame on every IDLE cycle regardless of start_in, giving continuous pings with period PERIOD_CYCLES+1.
REQ-029 SHALL, without PING_AUTO_REPEAT_EN, start frames only on start_in; done_out and trigger_out timing is identical in both builds.

Verification (HALF_PERIOD=4, BLANK_CYCLES=10, PERIOD_CYCLES=200, unless noted)
REQ-030 SHALL cover single ping: start_in pulse with burst_cycles_in=2 -> trigger_out single cycle; tx_out pattern 1111000011110000 (16 cycles); blanking_out high 26 cycles; done_out 200 cycles after trigger; busy_out high exactly 200 cycles.
REQ-031 SHALL cover N=0: burst_cycles_in=0 -> 8-cycle burst (one period); blanking_out high 18 cycles.
REQ-032 SHALL cover ignored request: start_in pulsed at f=50 -> no new trigger_out; start_in held high -> next trigger_out on the cycle done_out is high plus 1.
REQ-033 SHALL cover reset abort: rst_in asserted at f=6 -> all outputs 0 the next cycle, no done_out; start_in after release -> normal frame.
REQ-034 SHALL cover PING_AUTO_REPEAT_EN: start_in tied low -> trigger_out every 201 cycles, starting 1 cycle after reset release.
REQ-035 SHALL cover input stability: burst_cycles_in changed 3->1 at f=5 -> burst still 24 cycles.
